// File: rtl/multicycle_control_unit.sv
// Multi-cycle instruction sequencer: FETCH/DECODE/EXEC/MEM/WB with memory
// ready handshake, halt on stop/illegal opcodes and a saturating retire count.
//
// state  | meaning
// FETCH  | read instruction, wait for mem_ready, load IR and bump PC
// DECODE | latch opcode, pick next phase or halt
// EXEC   | drive ALU controls; branches/jmp finish here
// MEM    | ldw/stw memory access, wait for mem_ready
// WB     | register file write
// HALT   | stopped until rst
module multicycle_control_unit #(
  parameter int OPCODE_W = 4,
  parameter int ALUOP_W  = 2,
  parameter int CNT_W    = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                mem_ready,
  output logic                pc_write,
  output logic                ir_write,
  output logic [ALUOP_W-1:0]  alu_op,
  output logic                alu_src,
  output logic                branch,
  output logic                mem_read,
  output logic                mem_write,
  output logic                mem2reg,
  output logic                reg_write,
  output logic                halted,
  output logic                illegal,
  output logic [2:0]          state,
  output logic [CNT_W-1:0]    retired
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  localparam logic [3:0] OP_LDW  = 4'b0100;
  localparam logic [3:0] OP_STW  = 4'b0101;
  localparam logic [3:0] OP_STOP = 4'b1111;

  state_t     cur, nxt;
  logic [3:0] op_q;
  logic       retire;
  logic       upper_nz;

  // Any opcode bit above the decoded nibble makes the instruction illegal.
  if (OPCODE_W > 4) begin : g_upper
    assign upper_nz = |opcode[OPCODE_W-1:4];
  end else begin : g_no_upper
    assign upper_nz = 1'b0;
  end

  assign state  = cur;
  assign halted = (cur == S_HALT);

  // State, latched opcode, sticky illegal flag and saturating retire counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      cur     <= S_FETCH;
      op_q    <= 4'd0;
      illegal <= 1'b0;
      retired <= '0;
    end else begin
      cur <= nxt;
      if (cur == S_DECODE) begin
        op_q <= opcode[3:0];
        if (upper_nz) illegal <= 1'b1;
      end
      if (retire && (retired != {CNT_W{1'b1}})) retired <= retired + CNT_W'(1);
    end
  end

  // Next state and per-phase strobes; everything is forced quiet while rst is high.
  always_comb begin
    nxt       = cur;
    retire    = 1'b0;
    pc_write  = 1'b0;
    ir_write  = 1'b0;
    alu_op    = '0;
    alu_src   = 1'b0;
    branch    = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    mem2reg   = 1'b0;
    reg_write = 1'b0;
    case (cur)
      S_FETCH: begin
        mem_read = 1'b1;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          nxt      = S_DECODE;
        end
      end
      S_DECODE: begin
        if (upper_nz || (opcode[3:0] == OP_STOP)) nxt = S_HALT;
        else                                      nxt = S_EXEC;
      end
      S_EXEC: begin
        case (op_q)
          4'd0, 4'd1, 4'd2, 4'd3: begin
            alu_op = ALUOP_W'(op_q[1:0]);
            nxt    = S_WB;
          end
          OP_LDW, OP_STW: begin
            alu_src = 1'b1;
            nxt     = S_MEM;
          end
          4'd6, 4'd7: begin
            alu_src = 1'b1;
            nxt     = S_WB;
          end
          4'd8, 4'd9, 4'd10, 4'd11, 4'd12, 4'd13: begin
            alu_op = ALUOP_W'(1);
            branch = 1'b1;
            nxt    = S_FETCH;
            retire = 1'b1;
          end
          4'd14: begin
            branch = 1'b1;
            nxt    = S_FETCH;
            retire = 1'b1;
          end
          default: nxt = S_HALT;
        endcase
      end
      S_MEM: begin
        alu_src = 1'b1;
        if (op_q == OP_STW) mem_write = 1'b1;
        else                mem_read  = 1'b1;
        if (mem_ready) begin
          if (op_q == OP_STW) begin
            nxt    = S_FETCH;
            retire = 1'b1;
          end else begin
            nxt = S_WB;
          end
        end
      end
      S_WB: begin
        reg_write = 1'b1;
        mem2reg   = (op_q == OP_LDW);
        nxt       = S_FETCH;
        retire    = 1'b1;
      end
      S_HALT: nxt = S_HALT;
      default: nxt = S_FETCH;
    endcase
    if (rst) begin
      retire    = 1'b0;
      pc_write  = 1'b0;
      ir_write  = 1'b0;
      alu_op    = '0;
      alu_src   = 1'b0;
      branch    = 1'b0;
      mem_read  = 1'b0;
      mem_write = 1'b0;
      mem2reg   = 1'b0;
      reg_write = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Scoreboard bench for multicycle_control_unit: per-cycle stimulus and the
// expected state/strobes/retire count are queued together, then replayed.
module tb_multicycle_control_unit;

  localparam int OW = 6;
  localparam int CW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic [OW-1:0] opcode;
  logic          mem_ready;
  logic          pc_write, ir_write, alu_src, branch, mem_read, mem_write;
  logic          mem2reg, reg_write, halted, illegal;
  logic [1:0]    alu_op;
  logic [2:0]    state;
  logic [CW-1:0] retired;

  always #5 clk = ~clk;

  multicycle_control_unit #(.OPCODE_W(OW), .ALUOP_W(2), .CNT_W(CW)) u_dut (
    .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(pc_write), .ir_write(ir_write), .alu_op(alu_op), .alu_src(alu_src),
    .branch(branch), .mem_read(mem_read), .mem_write(mem_write), .mem2reg(mem2reg),
    .reg_write(reg_write), .halted(halted), .illegal(illegal), .state(state),
    .retired(retired)
  );

  typedef struct {
    logic          rst;
    logic          mr;
    logic [OW-1:0] op;
    logic [2:0]    st;
    logic [11:0]   sb;
    logic [CW-1:0] cnt;
  } item_t;

  item_t         q[$];
  int            n_tests = 0;
  int            n_fail  = 0;
  logic [CW-1:0] exp_cnt;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h, expected %h", tag, $time, got, exp);
    end
  endtask

  // {pc_write, ir_write, alu_op, alu_src, branch, mem_read, mem_write, mem2reg, reg_write, halted, illegal}
  function automatic logic [11:0] sb(input logic pcw, input logic irw, input logic [1:0] aop,
                                     input logic src, input logic br, input logic mrd,
                                     input logic mwr, input logic m2r, input logic rw,
                                     input logic h, input logic il);
    return {pcw, irw, aop, src, br, mrd, mwr, m2r, rw, h, il};
  endfunction

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic [OW-1:0] rnd();
    return OW'($urandom);
  endfunction

  task automatic push(input logic r, input logic m, input logic [OW-1:0] o,
                      input logic [2:0] s, input logic [11:0] b);
    item_t it;
    it.rst = r; it.mr = m; it.op = o; it.st = s; it.sb = b; it.cnt = exp_cnt;
    q.push_back(it);
  endtask

  task automatic retire();
    if (exp_cnt != {CW{1'b1}}) exp_cnt = exp_cnt + 1'b1;
  endtask

  task automatic do_rst(input logic [2:0] s, input logic h, input logic il, input logic m);
    push(1'b1, m, rnd(), s, sb(0, 0, 2'd0, 0, 0, 0, 0, 0, 0, h, il));
    exp_cnt = '0;
  endtask

  task automatic halt_cycles(input int n, input logic il);
    for (int i = 0; i < n; i++) push(1'b0, rb(), rnd(), 3'd5, sb(0, 0, 2'd0, 0, 0, 0, 0, 0, 0, 1, il));
  endtask

  // One instruction from FETCH; fw = FETCH wait cycles, mw = MEM wait cycles.
  task automatic instr(input logic [OW-1:0] o, input int fw, input int mw);
    logic [3:0] lo;
    lo = o[3:0];
    for (int i = 0; i < fw; i++) push(1'b0, 1'b0, rnd(), 3'd0, sb(0, 0, 2'd0, 0, 0, 1, 0, 0, 0, 0, 0));
    push(1'b0, 1'b1, rnd(), 3'd0, sb(1, 1, 2'd0, 0, 0, 1, 0, 0, 0, 0, 0));
    push(1'b0, rb(), o, 3'd1, 12'd0);
    if ((o[OW-1:4] != '0) || (lo == 4'hF)) return;
    case (lo)
      4'd0, 4'd1, 4'd2, 4'd3: begin
        push(1'b0, rb(), rnd(), 3'd2, sb(0, 0, lo[1:0], 0, 0, 0, 0, 0, 0, 0, 0));
        push(1'b0, rb(), rnd(), 3'd4, sb(0, 0, 2'd0, 0, 0, 0, 0, 0, 1, 0, 0));
        retire();
      end
      4'd4: begin
        push(1'b0, rb(), rnd(), 3'd2, sb(0, 0, 2'd0, 1, 0, 0, 0, 0, 0, 0, 0));
        for (int i = 0; i < mw; i++) push(1'b0, 1'b0, rnd(), 3'd3, sb(0, 0, 2'd0, 1, 0, 1, 0, 0, 0, 0, 0));
        push(1'b0, 1'b1, rnd(), 3'd3, sb(0, 0, 2'd0, 1, 0, 1, 0, 0, 0, 0, 0));
        push(1'b0, rb(), rnd(), 3'd4, sb(0, 0, 2'd0, 0, 0, 0, 0, 1, 1, 0, 0));
        retire();
      end
      4'd5: begin
        push(1'b0, rb(), rnd(), 3'd2, sb(0, 0, 2'd0, 1, 0, 0, 0, 0, 0, 0, 0));
        for (int i = 0; i < mw; i++) push(1'b0, 1'b0, rnd(), 3'd3, sb(0, 0, 2'd0, 1, 0, 0, 1, 0, 0, 0, 0));
        push(1'b0, 1'b1, rnd(), 3'd3, sb(0, 0, 2'd0, 1, 0, 0, 1, 0, 0, 0, 0));
        retire();
      end
      4'd6, 4'd7: begin
        push(1'b0, rb(), rnd(), 3'd2, sb(0, 0, 2'd0, 1, 0, 0, 0, 0, 0, 0, 0));
        push(1'b0, rb(), rnd(), 3'd4, sb(0, 0, 2'd0, 0, 0, 0, 0, 0, 1, 0, 0));
        retire();
      end
      4'd14: begin
        push(1'b0, rb(), rnd(), 3'd2, sb(0, 0, 2'd0, 0, 1, 0, 0, 0, 0, 0, 0));
        retire();
      end
      default: begin
        push(1'b0, rb(), rnd(), 3'd2, sb(0, 0, 2'd1, 0, 1, 0, 0, 0, 0, 0, 0));
        retire();
      end
    endcase
  endtask

  initial begin
    item_t it;
    exp_cnt = '0;

    do_rst(3'd0, 0, 0, 1'b1);
    // five ALU ops with a 2-bit counter: 1,2,3,3,3
    instr(6'h00, 0, 0);
    instr(6'h01, 1, 0);
    instr(6'h02, 0, 0);
    instr(6'h03, 0, 0);
    instr(6'h00, 0, 0);
    do_rst(3'd0, 0, 0, 1'b0);
    // ldw with three not-ready MEM cycles, then beq
    instr(6'h04, 0, 3);
    instr(6'h08, 0, 0);
    do_rst(3'd0, 0, 0, 1'b1);
    instr(6'h05, 1, 2);
    instr(6'h06, 0, 0);
    instr(6'h07, 0, 0);
    do_rst(3'd0, 0, 0, 1'b0);
    instr(6'h0D, 0, 0);
    instr(6'h0E, 0, 0);
    // stop: HALT, count frozen, inputs ignored
    instr(6'h0F, 0, 0);
    halt_cycles(4, 1'b0);
    do_rst(3'd5, 1, 0, 1'b1);
    // illegal upper opcode bit
    instr(6'h10, 0, 0);
    halt_cycles(3, 1'b1);
    do_rst(3'd5, 1, 1, 1'b1);
    instr(6'h08, 0, 0);
    // stw interrupted by rst in MEM with mem_ready high
    push(1'b0, 1'b1, rnd(), 3'd0, sb(1, 1, 2'd0, 0, 0, 1, 0, 0, 0, 0, 0));
    push(1'b0, 1'b1, 6'h05, 3'd1, 12'd0);
    push(1'b0, 1'b1, rnd(), 3'd2, sb(0, 0, 2'd0, 1, 0, 0, 0, 0, 0, 0, 0));
    do_rst(3'd3, 0, 0, 1'b1);
    push(1'b0, 1'b0, rnd(), 3'd0, sb(0, 0, 2'd0, 0, 0, 1, 0, 0, 0, 0, 0));

    rst       = 1'b1;
    mem_ready = 1'b0;
    opcode    = '0;
    repeat (2) @(posedge clk);
    #1;
    while (q.size() > 0) begin
      it        = q.pop_front();
      rst       = it.rst;
      mem_ready = it.mr;
      opcode    = it.op;
      @(negedge clk);
      chk("state", 16'(state), 16'(it.st));
      chk("strobes", 16'({pc_write, ir_write, alu_op, alu_src, branch, mem_read, mem_write,
                          mem2reg, reg_write, halted, illegal}), 16'(it.sb));
      chk("retired", 16'(retired), 16'(it.cnt));
      @(posedge clk);
      #1;
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
